// File: rtl/pic_pkg.sv
// pic_pkg: shared definitions for the pic_scalable interrupt controller.
// Holds the register map addresses, CTRL bit positions, the EOI specific-bit
// position, the acknowledge FSM state type and small priority helpers.
package pic_pkg;

  localparam logic [2:0] ADDR_IMR     = 3'd0;
  localparam logic [2:0] ADDR_CTRL    = 3'd1;
  localparam logic [2:0] ADDR_TRIG    = 3'd2;
  localparam logic [2:0] ADDR_VECBASE = 3'd3;
  localparam logic [2:0] ADDR_EOI     = 3'd4;
  localparam logic [2:0] ADDR_ISR     = 3'd5;

  localparam int CTRL_ROTATE = 0;
  localparam int CTRL_AEOI   = 1;
  localparam int CTRL_W      = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } pic_state_e;

  // The EOI command flags "specific" in the top bit of the data word.
  function automatic int eoi_spec_bit(input int data_w);
    return data_w - 1;
  endfunction

  // Priority rank of channel c when channel p is the highest: 0 = highest.
  function automatic int prio_rank(input int c, input int p, input int n);
    return (c >= p) ? (c - p) : (c + n - p);
  endfunction

  // Channel following c, wrapping at n.
  function automatic int next_chan(input int c, input int n);
    return (c == n - 1) ? 0 : c + 1;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver: combinational rotating priority encoder.
// Ports:
//   req_i   - request vector, one bit per channel
//   ptr_i   - channel that currently has the highest priority
//   valid_o - at least one request is set
//   id_o    - highest-priority requesting channel (searching upward from ptr_i)
module pic_priority_resolver
  import pic_pkg::*;
#(
  parameter  int N   = 8,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           valid_o,
  output logic [IDW-1:0] id_o
);

  // Channel visited at rank k when the search starts at p.
  function automatic logic [IDW-1:0] chan_at(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return IDW'((s >= N) ? (s - N) : s);
  endfunction

  // Scan from lowest to highest rank so the highest-priority hit is the last write.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      valid_o = valid_o | req_i[chan_at(ptr_i, k)];
      id_o    = req_i[chan_at(ptr_i, k)] ? chan_at(ptr_i, k) : id_o;
    end
  end

endmodule

// File: rtl/pic_scalable.sv
// pic_scalable: parametrised interrupt controller.
// Ports:
//   CLK, RESET         - clock, asynchronous active-high reset
//   IR                 - asynchronous request lines (bit 0 highest by default)
//   CS/WR/RD/ADDR/WDATA/RDATA - register port; RDATA registered, holds between reads
//   INT                - registered request to the CPU
//   INTA               - one-cycle acknowledge
//   VECTOR/VEC_VALID/SPURIOUS - acknowledge response, valid for one cycle
module pic_scalable
  import pic_pkg::*;
#(
  parameter int N_IRQ       = 8,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [N_IRQ-1:0]  IR,
  input  logic              CS,
  input  logic              WR,
  input  logic              RD,
  input  logic [2:0]        ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic [DATA_W-1:0] RDATA,
  output logic              INT,
  input  logic              INTA,
  output logic [DATA_W-1:0] VECTOR,
  output logic              VEC_VALID,
  output logic              SPURIOUS
);

  localparam int IDW      = $clog2(N_IRQ);
  localparam int SPEC_BIT = eoi_spec_bit(DATA_W);

  logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q, sync_d;
  logic [N_IRQ-1:0]  ir_prev_q, ir_prev_d;
  logic [N_IRQ-1:0]  irr_q, irr_d, isr_q, isr_d, imr_q, imr_d, trig_q, trig_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] vecbase_q, vecbase_d, rdata_q, rdata_d, vector_q, vector_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic              int_q, int_d, vec_valid_q, vec_valid_d, spurious_q, spurious_d;
  pic_state_e        state_q, state_d;

  logic [N_IRQ-1:0]  ir_s, rise_s, pend_s, eoi_clr_s, ack_set_s, ack_clr_s;
  logic [IDW-1:0]    ptr_eff_s, win_id_s, isr_id_s;
  logic              win_valid_s, isr_valid_s, wr_en_s, rd_en_s;
  logic [DATA_W-2:0] eoi_id_s;
  int                win_rank_s, isr_rank_s;

  assign ir_s      = sync_q[SYNC_STAGES-1];
  assign rise_s    = ir_s & ~ir_prev_q;
  assign pend_s    = irr_q & ~imr_q;
  assign ptr_eff_s = ctrl_q[CTRL_ROTATE] ? ptr_q : '0;
  assign wr_en_s   = CS & WR;
  assign rd_en_s   = CS & RD;
  assign eoi_id_s  = WDATA[DATA_W-2:0];

  pic_priority_resolver #(.N(N_IRQ)) u_req_res (
    .req_i  (pend_s),
    .ptr_i  (ptr_eff_s),
    .valid_o(win_valid_s),
    .id_o   (win_id_s)
  );

  pic_priority_resolver #(.N(N_IRQ)) u_isr_res (
    .req_i  (isr_q),
    .ptr_i  (ptr_eff_s),
    .valid_o(isr_valid_s),
    .id_o   (isr_id_s)
  );

  // Next-state logic: register writes/reads, EOI, acknowledge FSM, capture and INT.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], IR};
    ir_prev_d   = ir_s;
    imr_d       = imr_q;
    ctrl_d      = ctrl_q;
    trig_d      = trig_q;
    vecbase_d   = vecbase_q;
    ptr_d       = ptr_q;
    rdata_d     = rdata_q;
    state_d     = state_q;
    vector_d    = vector_q;
    vec_valid_d = 1'b0;
    spurious_d  = 1'b0;
    eoi_clr_s   = '0;
    ack_set_s   = '0;
    ack_clr_s   = '0;

    if (wr_en_s) begin
      case (ADDR)
        ADDR_IMR:     imr_d     = WDATA[N_IRQ-1:0];
        ADDR_CTRL:    ctrl_d    = WDATA[CTRL_W-1:0];
        ADDR_TRIG:    trig_d    = WDATA[N_IRQ-1:0];
        ADDR_VECBASE: vecbase_d = WDATA;
        ADDR_EOI: begin
          if (WDATA[SPEC_BIT]) begin
            if (int'(eoi_id_s) < N_IRQ) begin
              eoi_clr_s[eoi_id_s[IDW-1:0]] = 1'b1;
              ptr_d = ctrl_q[CTRL_ROTATE] ? IDW'(next_chan(int'(eoi_id_s), N_IRQ)) : ptr_d;
            end else begin
              eoi_clr_s = '0;
            end
          end else if (isr_valid_s) begin
            eoi_clr_s[isr_id_s] = 1'b1;
            ptr_d = ctrl_q[CTRL_ROTATE] ? IDW'(next_chan(int'(isr_id_s), N_IRQ)) : ptr_d;
          end else begin
            eoi_clr_s = '0;
          end
        end
        default: imr_d = imr_q;
      endcase
    end else begin
      imr_d = imr_q;
    end

    if (rd_en_s) begin
      case (ADDR)
        ADDR_IMR:     rdata_d = DATA_W'(imr_q);
        ADDR_CTRL:    rdata_d = DATA_W'(ctrl_q);
        ADDR_TRIG:    rdata_d = DATA_W'(trig_q);
        ADDR_VECBASE: rdata_d = vecbase_q;
        ADDR_EOI:     rdata_d = DATA_W'(irr_q);
        ADDR_ISR:     rdata_d = DATA_W'(isr_q);
        default:      rdata_d = '0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end

    // Acknowledge handling; evaluated after EOI so an AEOI rotation takes the pointer.
    case (state_q)
      IDLE: begin
        if (INTA) begin
          state_d     = ACK;
          vec_valid_d = 1'b1;
          if (win_valid_s) begin
            vector_d = vecbase_q + DATA_W'(win_id_s);
            if (!ctrl_q[CTRL_AEOI]) begin
              ack_set_s[win_id_s] = 1'b1;
            end else begin
              ptr_d = ctrl_q[CTRL_ROTATE] ? IDW'(next_chan(int'(win_id_s), N_IRQ)) : ptr_d;
            end
            ack_clr_s[win_id_s] = trig_q[win_id_s];
          end else begin
            vector_d   = vecbase_q + DATA_W'(N_IRQ - 1);
            spurious_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Edge channels: a new edge beats an acknowledge clear. Level channels track the input.
    irr_d = (trig_q & ((irr_q & ~ack_clr_s) | rise_s)) | (~trig_q & ir_s);
    // An acknowledge set beats an EOI clear of the same bit.
    isr_d = (isr_q & ~eoi_clr_s) | ack_set_s;

    win_rank_s = prio_rank(int'(win_id_s), int'(ptr_eff_s), N_IRQ);
    isr_rank_s = prio_rank(int'(isr_id_s), int'(ptr_eff_s), N_IRQ);
    int_d      = win_valid_s & (~isr_valid_s | (win_rank_s < isr_rank_s));
  end

  // State registers; RESET clears everything at once, including an acknowledge in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q      <= '0;
      ir_prev_q   <= '0;
      irr_q       <= '0;
      isr_q       <= '0;
      imr_q       <= '1;
      trig_q      <= '1;
      ctrl_q      <= '0;
      vecbase_q   <= '0;
      ptr_q       <= '0;
      rdata_q     <= '0;
      int_q       <= 1'b0;
      vector_q    <= '0;
      vec_valid_q <= 1'b0;
      spurious_q  <= 1'b0;
      state_q     <= IDLE;
    end else begin
      sync_q      <= sync_d;
      ir_prev_q   <= ir_prev_d;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      imr_q       <= imr_d;
      trig_q      <= trig_d;
      ctrl_q      <= ctrl_d;
      vecbase_q   <= vecbase_d;
      ptr_q       <= ptr_d;
      rdata_q     <= rdata_d;
      int_q       <= int_d;
      vector_q    <= vector_d;
      vec_valid_q <= vec_valid_d;
      spurious_q  <= spurious_d;
      state_q     <= state_d;
    end
  end

  assign RDATA     = rdata_q;
  assign INT       = int_q;
  assign VECTOR    = vector_q;
  assign VEC_VALID = vec_valid_q;
  assign SPURIOUS  = spurious_q;

endmodule

// File: tb/tb_pic_scalable.sv
// tb_pic_scalable: self-checking bench for pic_scalable (N_IRQ=8, DATA_W=8, SYNC_STAGES=2).
// Register-port vector table, directed multi-cycle sequences and a randomized
// phase checked against a transaction-level priority model.
module tb_pic_scalable;

  localparam int N_IRQ       = 8;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b1;
  logic       CS    = 1'b0;
  logic       WR    = 1'b0;
  logic       RD    = 1'b0;
  logic       INTA  = 1'b0;
  logic [2:0] ADDR  = 3'd0;
  logic [7:0] WDATA = 8'h00;
  logic [7:0] IR    = 8'h00;
  logic [7:0] RDATA, VECTOR;
  logic       INT, VEC_VALID, SPURIOUS;

  int total  = 0;
  int passed = 0;

  pic_scalable #(.N_IRQ(N_IRQ), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .CLK(CLK), .RESET(RESET), .IR(IR), .CS(CS), .WR(WR), .RD(RD), .ADDR(ADDR),
    .WDATA(WDATA), .RDATA(RDATA), .INT(INT), .INTA(INTA), .VECTOR(VECTOR),
    .VEC_VALID(VEC_VALID), .SPURIOUS(SPURIOUS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       wr;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } reg_vec_t;

  reg_vec_t tbl [17];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    ADDR = a; WDATA = d; CS = 1'b1; WR = 1'b1;
    tick();
    CS = 1'b0; WR = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
    ADDR = a; CS = 1'b1; RD = 1'b1;
    tick();
    CS = 1'b0; RD = 1'b0;
    d = RDATA;
  endtask

  // Acknowledge, check the one-cycle response, then let the FSM return to idle.
  task automatic ack_check(input string name, input logic [7:0] exp_vec, input logic exp_spur);
    INTA = 1'b1;
    tick();
    INTA = 1'b0;
    check({name, "_valid"}, 32'(VEC_VALID), 32'd1);
    check({name, "_vector"}, 32'(VECTOR), 32'(exp_vec));
    check({name, "_spurious"}, 32'(SPURIOUS), 32'(exp_spur));
    tick();
    check({name, "_valid_drop"}, 32'(VEC_VALID), 32'd0);
  endtask

  // Bounded wait for INT to reach a value; an expired budget is a failed check.
  task automatic wait_int(input string name, input logic exp, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (INT === exp) break;
    end
    check(name, 32'(INT), 32'(exp));
  endtask

  // Reference priority: first pending channel found walking upward from ptr.
  function automatic int model_winner(input logic [7:0] pend, input int ptr);
    for (int k = 0; k < N_IRQ; k++) begin
      if (pend[(ptr + k) % N_IRQ]) return (ptr + k) % N_IRQ;
    end
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, m, p, base, m_irr;
    logic       rot;
    int         m_ptr, w;

    tbl[0]  = '{1'b0, 3'd0, 8'h00, 8'hFF};
    tbl[1]  = '{1'b0, 3'd1, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 3'd2, 8'h00, 8'hFF};
    tbl[3]  = '{1'b0, 3'd3, 8'h00, 8'h00};
    tbl[4]  = '{1'b0, 3'd4, 8'h00, 8'h00};
    tbl[5]  = '{1'b0, 3'd5, 8'h00, 8'h00};
    tbl[6]  = '{1'b0, 3'd6, 8'h00, 8'h00};
    tbl[7]  = '{1'b1, 3'd0, 8'hA5, 8'hA5};
    tbl[8]  = '{1'b1, 3'd1, 8'hFF, 8'h03};
    tbl[9]  = '{1'b1, 3'd2, 8'h3C, 8'h3C};
    tbl[10] = '{1'b1, 3'd3, 8'h40, 8'h40};
    tbl[11] = '{1'b1, 3'd6, 8'h55, 8'h00};
    tbl[12] = '{1'b1, 3'd7, 8'hAA, 8'h00};
    tbl[13] = '{1'b1, 3'd5, 8'hFF, 8'h00};
    tbl[14] = '{1'b1, 3'd0, 8'h00, 8'h00};
    tbl[15] = '{1'b1, 3'd2, 8'hFF, 8'hFF};
    tbl[16] = '{1'b1, 3'd1, 8'h00, 8'h00};

    // Reset
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    tick();
    check("rst_int", 32'(INT), 32'd0);
    check("rst_vec_valid", 32'(VEC_VALID), 32'd0);
    check("rst_spurious", 32'(SPURIOUS), 32'd0);
    check("rst_vector", 32'(VECTOR), 32'd0);
    check("rst_rdata", 32'(RDATA), 32'd0);

    // Register map: reset values, read/write, zero fill, reserved and read-only
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].wr) wr_reg(tbl[i].addr, tbl[i].wdata);
      rd_reg(tbl[i].addr, d);
      check($sformatf("reg_vec%0d", i), 32'(d), 32'(tbl[i].exp));
    end

    // Seq 1: edge request on channel 3, acknowledge
    IR = 8'h08;
    wait_int("s1_int", 1'b1, SYNC_STAGES + 2);
    IR = 8'h00;
    ack_check("s1_ack", 8'h43, 1'b0);
    rd_reg(3'd5, d); check("s1_isr", 32'(d), 32'h08);
    tick(); tick();
    check("s1_rdata_hold", 32'(RDATA), 32'h08);
    rd_reg(3'd4, d); check("s1_irr", 32'(d), 32'h00);

    // Seq 2: lower priority blocked by ISR, higher one nests, non-specific EOI
    IR = 8'h20; tick(); IR = 8'h00;
    repeat (SYNC_STAGES + 3) tick();
    check("s2_int_blocked", 32'(INT), 32'd0);
    IR = 8'h02;
    wait_int("s2_int_nest", 1'b1, SYNC_STAGES + 2);
    IR = 8'h00;
    ack_check("s2_ack", 8'h41, 1'b0);
    rd_reg(3'd5, d); check("s2_isr_nest", 32'(d), 32'h0A);
    wr_reg(3'd4, 8'h00);
    rd_reg(3'd5, d); check("s2_isr_nseoi", 32'(d), 32'h08);
    wr_reg(3'd4, 8'h83);
    wait_int("s2_int_ch5", 1'b1, 3);
    ack_check("s2_ack5", 8'h45, 1'b0);
    wr_reg(3'd4, 8'h85);
    rd_reg(3'd5, d); check("s2_isr_clean", 32'(d), 32'h00);

    // Seq 3: rotating priority
    wr_reg(3'd1, 8'h01);
    IR = 8'h05; tick(); IR = 8'h00;
    repeat (SYNC_STAGES + 2) tick();
    ack_check("s3_ack0", 8'h40, 1'b0);
    wr_reg(3'd4, 8'h80);
    ack_check("s3_ack2", 8'h42, 1'b0);
    IR = 8'h03; tick(); IR = 8'h00;
    repeat (SYNC_STAGES + 2) tick();
    check("s3_int_ch1", 32'(INT), 32'd1);
    ack_check("s3_ack1", 8'h41, 1'b0);
    wr_reg(3'd1, 8'h00);
    wr_reg(3'd4, 8'h81);
    wr_reg(3'd4, 8'h82);
    rd_reg(3'd5, d); check("s3_isr_clean", 32'(d), 32'h00);

    // Seq 4: all masked -> spurious
    wr_reg(3'd0, 8'hFF);
    IR = 8'h10;
    repeat (SYNC_STAGES + 2) tick();
    ack_check("s4_spur", 8'h47, 1'b1);
    rd_reg(3'd5, d); check("s4_isr", 32'(d), 32'h00);
    rd_reg(3'd4, d); check("s4_irr", 32'(d), 32'h11);
    IR = 8'h00;

    // Seq 5: level channel 6 with auto-EOI
    wr_reg(3'd2, 8'hBF);
    wr_reg(3'd1, 8'h02);
    wr_reg(3'd0, 8'hBF);
    IR = 8'h40;
    wait_int("s5_int", 1'b1, SYNC_STAGES + 2);
    ack_check("s5_ack", 8'h46, 1'b0);
    rd_reg(3'd5, d); check("s5_isr", 32'(d), 32'h00);
    check("s5_int_level", 32'(INT), 32'd1);
    IR = 8'h00;
    wait_int("s5_int_drop", 1'b0, SYNC_STAGES + 2);
    rd_reg(3'd4, d); check("s5_irr", 32'(d), 32'h11);

    // Seq 6: reset during the acknowledge cycle
    wr_reg(3'd0, 8'h00);
    wait_int("s6_int", 1'b1, 3);
    INTA = 1'b1; tick(); INTA = 1'b0;
    check("s6_in_ack", 32'(VEC_VALID), 32'd1);
    check("s6_vector", 32'(VECTOR), 32'h40);
    #2 RESET = 1'b1;
    #1;
    check("s6_rst_valid", 32'(VEC_VALID), 32'd0);
    check("s6_rst_int", 32'(INT), 32'd0);
    tick(); tick();
    RESET = 1'b0;
    tick();
    rd_reg(3'd0, d); check("s6_imr", 32'(d), 32'hFF);

    // Randomized phase against the transaction-level model (all channels edge)
    base = 8'($urandom);
    wr_reg(3'd3, base);
    m_irr = 8'h00;
    m_ptr = 0;
    for (int it = 0; it < 40; it++) begin
      rot = 1'($urandom_range(0, 1));
      wr_reg(3'd1, {7'd0, rot});
      m = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      wr_reg(3'd0, m);
      p = 8'($urandom) & 8'($urandom);
      IR = p; tick(); IR = 8'h00;
      m_irr = m_irr | p;
      repeat (SYNC_STAGES + 2) tick();
      check("rand_int", 32'(INT), 32'((m_irr & ~m) != 8'h00));
      w = model_winner(m_irr & ~m, rot ? m_ptr : 0);
      if (w >= 0) begin
        ack_check("rand_ack", base + 8'(w), 1'b0);
        m_irr[w] = 1'b0;
        wr_reg(3'd4, 8'h80 | 8'(w));
        if (rot) m_ptr = (w + 1) % N_IRQ;
      end else begin
        ack_check("rand_spur", base + 8'(N_IRQ - 1), 1'b1);
      end
      rd_reg(3'd4, d); check("rand_irr", 32'(d), 32'(m_irr));
      rd_reg(3'd5, d); check("rand_isr", 32'(d), 32'h00);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
